// File: rtl/washer_pkg.sv
// washer_pkg: shared run-state encodings, water limits and valve FSM states
package washer_pkg;
  localparam logic [1:0] RS_IDLE  = 2'b00;
  localparam logic [1:0] RS_RUN   = 2'b01;
  localparam logic [1:0] RS_PAUSE = 2'b10;
  localparam logic [2:0] WATER_MIN = 3'd2;
  localparam logic [2:0] WATER_MAX = 3'd5;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN} valve_state_e;
  function automatic logic [2:0] clamp_level(input logic [2:0] t);
    return t < WATER_MIN ? WATER_MIN : (t > WATER_MAX ? WATER_MAX : t);
  endfunction
endpackage

// File: rtl/water_valve_ctrl_unit_timer.sv
// unit_timer: counts tick pulses and flags the tick that completes one water unit
//   clk, rst_n      clock, async active-low reset
//   enable, clear   count ticks when enable; clear zeroes the count (wins)
//   tick            timebase enable pulse
//   term_cnt        ticks per unit (>= 1)
//   unit_done       high on the tick that completes a unit (counter wraps to 0)
module unit_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] term_cnt,
  output logic         unit_done
);
  logic [W-1:0] cnt_q;
  assign unit_done = enable && !clear && tick && cnt_q == term_cnt - 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (enable && tick) cnt_q <= unit_done ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/water_valve_ctrl.sv
// water_valve_ctrl: fills the tub to the panel level and drains it on sequencer request
//   clk, rst_n                 clock, async active-low reset
//   tick                       timebase pulse
//   power_light, run_state     machine power and run/pause/stop state
//   target_water               panel level (clamped to 2..5 when latched)
//   fill_req, drain_req        one-cycle requests (drain wins)
//   inlet_valve, drain_valve   valve drives
//   water_level                tub level in units
//   fill_done, drain_done      one-cycle completion pulses
//   busy                       high during FILL or DRAIN, paused included
module water_valve_ctrl
  import washer_pkg::*;
#(
  parameter int TICKS_PER_UNIT       = 4,
  parameter int DRAIN_TICKS_PER_UNIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       power_light,
  input  logic [1:0] run_state,
  input  logic [2:0] target_water,
  input  logic       fill_req,
  input  logic       drain_req,
  output logic       inlet_valve,
  output logic       drain_valve,
  output logic [2:0] water_level,
  output logic       fill_done,
  output logic       drain_done,
  output logic       busy
);
  localparam int TMAX = TICKS_PER_UNIT > DRAIN_TICKS_PER_UNIT ? TICKS_PER_UNIT : DRAIN_TICKS_PER_UNIT;
  localparam int CW   = $clog2(TMAX + 1);
  valve_state_e state_q;
  logic [2:0] level_q, target_q, clamped;
  logic inlet_q, drain_q, fill_done_q, drain_done_q, busy_q;
  logic unit_done;
  logic [CW-1:0] term;
  assign clamped = clamp_level(target_water);
  assign term = state_q == ST_DRAIN ? CW'(DRAIN_TICKS_PER_UNIT) : CW'(TICKS_PER_UNIT);
  // Counter is held at zero in IDLE so every fill or drain starts a fresh unit.
  unit_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (power_light && run_state == RS_RUN && state_q != ST_IDLE),
    .clear    (state_q == ST_IDLE || !power_light),
    .tick     (tick),
    .term_cnt (term),
    .unit_done(unit_done)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      target_q     <= WATER_MIN;
      inlet_q      <= 1'b0;
      drain_q      <= 1'b0;
      fill_done_q  <= 1'b0;
      drain_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      fill_done_q  <= 1'b0;
      drain_done_q <= 1'b0;
      if (!power_light) begin
        state_q <= ST_IDLE;
        inlet_q <= 1'b0;
        drain_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (run_state == RS_RUN) begin
              if (drain_req) begin
                if (level_q == 3'd0) drain_done_q <= 1'b1;
                else begin
                  state_q <= ST_DRAIN;
                  busy_q  <= 1'b1;
                end
              end else if (fill_req) begin
                target_q <= clamped;
                if (level_q >= clamped) fill_done_q <= 1'b1;
                else begin
                  state_q <= ST_FILL;
                  busy_q  <= 1'b1;
                end
              end
            end
          end
          ST_FILL: begin
            if (run_state == RS_IDLE) begin
              state_q <= ST_IDLE;
              inlet_q <= 1'b0;
              busy_q  <= 1'b0;
            end else if (unit_done && level_q + 3'd1 == target_q) begin
              level_q     <= target_q;
              state_q     <= ST_IDLE;
              inlet_q     <= 1'b0;
              busy_q      <= 1'b0;
              fill_done_q <= 1'b1;
            end else begin
              if (unit_done) level_q <= level_q + 3'd1;
              inlet_q <= run_state == RS_RUN;
            end
          end
          ST_DRAIN: begin
            if (run_state == RS_IDLE) begin
              state_q <= ST_IDLE;
              drain_q <= 1'b0;
              busy_q  <= 1'b0;
            end else if (unit_done && level_q == 3'd1) begin
              level_q      <= 3'd0;
              state_q      <= ST_IDLE;
              drain_q      <= 1'b0;
              busy_q       <= 1'b0;
              drain_done_q <= 1'b1;
            end else begin
              if (unit_done) level_q <= level_q - 3'd1;
              drain_q <= run_state == RS_RUN;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end
  assign inlet_valve = inlet_q;
  assign drain_valve = drain_q;
  assign water_level = level_q;
  assign fill_done   = fill_done_q;
  assign drain_done  = drain_done_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_water_valve_ctrl.sv
// tb_water_valve_ctrl: directed and random stimulus checked against a tick-accumulating reference model
module tb_water_valve_ctrl;
  localparam int TPU  = 4;
  localparam int DTPU = 2;
  logic clk = 1'b0;
  logic rst_n, tick, power_light, fill_req, drain_req;
  logic [1:0] run_state;
  logic [2:0] target_water;
  logic inlet_valve, drain_valve, fill_done, drain_done, busy;
  logic [2:0] water_level;
  int n_cmp = 0;
  int n_err = 0;
  string phase = "init";
  int m_mode, m_start, m_ticks, m_tgt, m_level;
  logic m_in, m_dr, m_fd, m_dd, m_busy;
  always #5 clk = ~clk;
  water_valve_ctrl #(.TICKS_PER_UNIT(TPU), .DRAIN_TICKS_PER_UNIT(DTPU)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .power_light (power_light),
    .run_state   (run_state),
    .target_water(target_water),
    .fill_req    (fill_req),
    .drain_req   (drain_req),
    .inlet_valve (inlet_valve),
    .drain_valve (drain_valve),
    .water_level (water_level),
    .fill_done   (fill_done),
    .drain_done  (drain_done),
    .busy        (busy)
  );
  function automatic int clamp(int t);
    return t < 2 ? 2 : (t > 5 ? 5 : t);
  endfunction
  task automatic model_reset();
    m_mode = 0; m_start = 0; m_ticks = 0; m_tgt = 2; m_level = 0;
    m_in = 0; m_dr = 0; m_fd = 0; m_dd = 0; m_busy = 0;
  endtask
  // Mode 0 idle, 1 fill, 2 drain; level is the start level plus whole units of running ticks.
  task automatic model_step();
    m_fd = 0;
    m_dd = 0;
    if (!power_light) begin
      m_mode = 0; m_in = 0; m_dr = 0; m_busy = 0;
    end else if (m_mode == 0) begin
      if (run_state == 2'b01) begin
        if (drain_req) begin
          if (m_level == 0) m_dd = 1;
          else begin m_mode = 2; m_start = m_level; m_ticks = 0; m_busy = 1; end
        end else if (fill_req) begin
          if (m_level >= clamp(int'(target_water))) m_fd = 1;
          else begin m_mode = 1; m_start = m_level; m_tgt = clamp(int'(target_water)); m_ticks = 0; m_busy = 1; end
        end
      end
    end else if (run_state == 2'b00) begin
      m_mode = 0; m_in = 0; m_dr = 0; m_busy = 0;
    end else begin
      if (run_state == 2'b01 && tick) m_ticks++;
      m_level = m_mode == 1 ? m_start + m_ticks / TPU : m_start - m_ticks / DTPU;
      if (m_level == (m_mode == 1 ? m_tgt : 0)) begin
        if (m_mode == 1) m_fd = 1; else m_dd = 1;
        m_mode = 0; m_in = 0; m_dr = 0; m_busy = 0;
      end else begin
        m_in = m_mode == 1 && run_state == 2'b01;
        m_dr = m_mode == 2 && run_state == 2'b01;
      end
    end
  endtask
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("inlet_valve", 8'(inlet_valve), 8'(m_in));
    chk("drain_valve", 8'(drain_valve), 8'(m_dr));
    chk("water_level", 8'(water_level), 8'(m_level));
    chk("fill_done",   8'(fill_done),   8'(m_fd));
    chk("drain_done",  8'(drain_done),  8'(m_dd));
    chk("busy",        8'(busy),        8'(m_busy));
  endtask
  task automatic step(input logic tk);
    tick = tk;
    model_step();
    @(posedge clk);
    #1;
    check_all();
    fill_req = 0;
    drain_req = 0;
    tick = 0;
  endtask
  task automatic pulse_ticks(input int n);
    repeat (n) begin
      step(1'b1);
      step(1'b0);
    end
  endtask
  initial begin
    rst_n = 0; tick = 0; power_light = 1; run_state = 2'b00;
    target_water = 3'd0; fill_req = 0; drain_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    check_all();
    rst_n = 1;
    phase = "fill_empty";
    run_state = 2'b01; target_water = 3'd3; fill_req = 1;
    step(1'b0);
    chk("accept_inlet_low", 8'(inlet_valve), 8'd0);
    chk("accept_busy", 8'(busy), 8'd1);
    step(1'b0);
    chk("inlet_rise", 8'(inlet_valve), 8'd1);
    pulse_ticks(11);
    chk("level_before_last", 8'(water_level), 8'd2);
    step(1'b1);
    chk("fill3_done", 8'(fill_done), 8'd1);
    chk("fill3_inlet_off", 8'(inlet_valve), 8'd0);
    chk("fill3_level", 8'(water_level), 8'd3);
    step(1'b0);
    phase = "simultaneous";
    fill_req = 1; drain_req = 1;
    step(1'b0);
    step(1'b0);
    chk("sim_drain_open", 8'(drain_valve), 8'd1);
    chk("sim_no_inlet", 8'(inlet_valve), 8'd0);
    pulse_ticks(6);
    chk("sim_level0", 8'(water_level), 8'd0);
    phase = "clamp_high";
    target_water = 3'd7; fill_req = 1;
    step(1'b0);
    pulse_ticks(20);
    chk("clamp_level5", 8'(water_level), 8'd5);
    phase = "already_full";
    target_water = 3'd2; fill_req = 1;
    step(1'b0);
    chk("full_done", 8'(fill_done), 8'd1);
    chk("full_busy", 8'(busy), 8'd0);
    step(1'b0);
    chk("full_inlet_closed", 8'(inlet_valve), 8'd0);
    phase = "drain_empty";
    drain_req = 1;
    step(1'b0);
    pulse_ticks(10);
    chk("drain_level0", 8'(water_level), 8'd0);
    drain_req = 1;
    step(1'b0);
    chk("empty_drain_done", 8'(drain_done), 8'd1);
    phase = "pause";
    target_water = 3'd5; fill_req = 1;
    step(1'b0);
    pulse_ticks(6);
    chk("pause_pre_level", 8'(water_level), 8'd1);
    run_state = 2'b10;
    pulse_ticks(10);
    chk("paused_level", 8'(water_level), 8'd1);
    chk("paused_inlet", 8'(inlet_valve), 8'd0);
    chk("paused_busy", 8'(busy), 8'd1);
    run_state = 2'b01;
    step(1'b0);
    pulse_ticks(1);
    chk("resume_level_hold", 8'(water_level), 8'd1);
    pulse_ticks(1);
    chk("resume_level2", 8'(water_level), 8'd2);
    pulse_ticks(12);
    chk("pause_level5", 8'(water_level), 8'd5);
    phase = "power_loss";
    drain_req = 1;
    step(1'b0);
    pulse_ticks(10);
    target_water = 3'd4; fill_req = 1;
    step(1'b0);
    pulse_ticks(9);
    chk("pl_level2", 8'(water_level), 8'd2);
    power_light = 0;
    step(1'b1);
    chk("pl_busy", 8'(busy), 8'd0);
    chk("pl_inlet", 8'(inlet_valve), 8'd0);
    chk("pl_level", 8'(water_level), 8'd2);
    step(1'b0);
    power_light = 1;
    phase = "gating";
    run_state = 2'b00; fill_req = 1;
    step(1'b0);
    chk("gate_stopped", 8'(busy), 8'd0);
    run_state = 2'b01; fill_req = 1;
    step(1'b0);
    pulse_ticks(1);
    fill_req = 1;
    step(1'b0);
    chk("gate_busy", 8'(busy), 8'd1);
    chk("gate_inlet", 8'(inlet_valve), 8'd1);
    phase = "abort";
    run_state = 2'b00;
    step(1'b1);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_level", 8'(water_level), 8'd2);
    phase = "async_reset";
    run_state = 2'b01; drain_req = 1;
    step(1'b0);
    pulse_ticks(1);
    #2 rst_n = 0;
    #1;
    chk("ar_drain", 8'(drain_valve), 8'd0);
    chk("ar_busy", 8'(busy), 8'd0);
    chk("ar_level", 8'(water_level), 8'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    phase = "random";
    repeat (800) begin
      power_light  = $urandom_range(0, 31) != 0;
      run_state    = $urandom_range(0, 9) < 7 ? 2'b01 : 2'($urandom_range(0, 3));
      target_water = 3'($urandom_range(0, 7));
      fill_req     = $urandom_range(0, 7) == 0;
      drain_req    = $urandom_range(0, 11) == 0;
      step($urandom_range(0, 2) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/water_valve_ctrl.md
# water_valve_ctrl

Executes the water level chosen on the panel. It opens the inlet valve until the tub holds the selected level, and opens the drain valve until the tub is empty. Each fill or drain runs on one request from the wash sequencer and honours the machine's pause and power state. The block sits between the panel's 3-bit water-level setting and the valve drivers, and reports completion back to the sequencer.

## Interface
- TICKS_PER_UNIT, 4: `tick` pulses of inlet flow per water unit; legal range ≥ 1.
- DRAIN_TICKS_PER_UNIT, 2: `tick` pulses of drain flow per water unit; legal range ≥ 1.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle timebase enable (1 Hz domain pulse, synchronous to clk).
- power_light  input  1  1 = machine powered.
- run_state  input  2  00 = not started, 01 = running, 10 = paused, 11 = treated as paused.
- target_water  input  3  selected level, in units; valid 2..5.
- fill_req  input  1  one-cycle request: fill to target.
- drain_req  input  1  one-cycle request: drain to 0.
- inlet_valve  output  1  1 = inlet open.
- drain_valve  output  1  1 = drain open.
- water_level  output  3  current tub level in units, 0..5.
- fill_done  output  1  one-cycle pulse when a fill completes.
- drain_done  output  1  one-cycle pulse when a drain completes.
- busy  output  1  1 while in FILL or DRAIN, including while paused.

## Operation
- Reset (rst_n = 0, asynchronous) drives:
  - state to IDLE;
  - both valves, both done pulses and busy to 0;
  - water_level to 0 and the unit counter to 0.
- States: IDLE, FILL, DRAIN.
- IDLE:
  - Requests are accepted only when power_light = 1 and run_state = 01; otherwise they are dropped.
  - If drain_req and fill_req are asserted together, drain_req wins.
- Accepting fill_req:
  - Latch the target, clamped to 2..5 (values 0–1 become 2, values 6–7 become 5).
  - If water_level ≥ latched target: stay in IDLE and pulse fill_done on the next cycle. No valve opens.
  - Otherwise go to FILL and clear the unit counter.
- Accepting drain_req:
  - If water_level = 0: pulse drain_done on the next cycle. No valve opens.
  - Otherwise go to DRAIN and clear the unit counter.
- FILL:
  - inlet_valve = 1 while run_state = 01; 0 when paused.
  - On each tick while running, the unit counter increments.
  - When the counter reaches TICKS_PER_UNIT−1 on a tick: the counter returns to 0 and water_level increments.
  - When water_level becomes equal to the target on that edge, the same edge also sets state to IDLE, inlet_valve to 0 and fill_done to 1.
- DRAIN: mirrors FILL. drain_valve is used, the count runs to DRAIN_TICKS_PER_UNIT, water_level decrements, and the drain ends at 0 with drain_done.
- Pause (run_state 10 or 11): the state, unit counter and level are held and both valves are 0. Resuming to 01 continues from the held count.
- run_state = 00 while busy is treated as an abort:
  - return to IDLE, close the valves, keep water_level;
  - no done pulse.
- power_light = 0 forces the following on the next edge:
  - state to IDLE and valves closed;
  - counter cleared and water_level held, since the water remains in the tub.
- Requests arriving while busy are ignored.
- target_water changes during FILL have no effect, because the target is latched.
- water_level never goes above 5 or below 0.

## Timing
- All outputs are registered.
- A request accepted at edge N gives valve = 1 from edge N+1.
- The first unit counts from the first tick after edge N.
- A fill from level L to target T takes (T−L)·TICKS_PER_UNIT running ticks.
- The done pulse is exactly one clk wide. It is asserted in the same cycle the valve drops and busy falls.
- A tick coincident with a pause or power loss is not counted.

## Structure
- Shared package `washer_pkg`:
  - run_state encodings (RS_IDLE, RS_RUN, RS_PAUSE);
  - WATER_MIN = 2, WATER_MAX = 5;
  - the valve controller state enum.
- One sub-module, `unit_timer`:
  - parameterised terminal count;
  - inputs: enable, clear, tick;
  - output: a one-cycle `unit_done` pulse.
- One unit_timer instance is shared by FILL and DRAIN, with the terminal count selected by state.

## Test plan
- Fill from empty: reset; run_state = 01, target = 3, fill_req. Required: inlet_valve rises 1 cycle later; water_level steps 1, 2, 3 every 4 ticks; fill_done pulses with inlet_valve falling after tick 12.
- Out-of-range target: with level 0, target_water = 7 then fill_req. Required: fill to 5 in 20 ticks. With level 5, target = 2: fill_done the next cycle, inlet never opens.
- Pause mid-fill: pause (run_state = 10) after 2 ticks of the second unit, apply 10 ticks, then resume. Required: valve 0 and level frozen while paused; the second unit completes 2 running ticks after resume.
- Simultaneous requests: level 3, fill_req and drain_req together. Required: DRAIN; level 3→0 over 6 ticks; drain_done once; fill never starts.
- Power loss and reset: power_light = 0 mid-fill at level 2. Required: valves 0 and IDLE next cycle, level stays 2, no done pulse. rst_n asserted mid-drain: all outputs 0 immediately, without waiting for clk.
- Request gating: fill_req with run_state = 00, and a second fill_req while busy. Required: both ignored; busy and valves unchanged.
